// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: registered priority encoder with LSB-first, MSB-first and
// round-robin selection, behind a one-deep valid/ready output stage.
// A result is presented one cycle after its request is accepted. A new
// request may be accepted in the same cycle that the consumer takes the
// previous result, so the block sustains one result per clock.
module prio_encoder_rr #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] req,
  input  logic [1:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] code,
  output logic         zero,
  output logic         multi
);

  typedef enum logic [1:0] {
    MODE_LSB  = 2'b00,
    MODE_MSB  = 2'b01,
    MODE_RR   = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  logic         r_out_valid;
  logic [W-1:0] r_code;
  logic         r_zero;
  logic         r_multi;
  logic [W-1:0] r_ptr;

  logic         w_in_xfer;
  logic         w_out_xfer;
  logic [W-1:0] w_rr_start;
  logic [W-1:0] w_lsb_code;
  logic [W-1:0] w_msb_code;
  logic [W-1:0] w_rr_code;
  logic [W-1:0] w_sel_code;
  logic         w_zero;
  logic         w_multi;

  // The output register can take a new result when it is empty or being drained.
  assign in_ready   = !r_out_valid || out_ready;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // The round-robin search starts just past the last grant and wraps at N-1,
  // which is not necessarily 2^W-1.
  assign w_rr_start = (r_ptr == W'(N - 1)) ? '0 : r_ptr + 1'b1;

  // Lowest and highest set bit. Each loop lets the winning bit write last.
  always_comb begin
    // NOTE: every combinational output gets a default before any condition so
    // that no path leaves it unassigned, which would infer a latch.
    w_lsb_code = '0;
    w_msb_code = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) w_lsb_code = W'(i);
    end
    for (int i = 0; i < N; i++) begin
      if (req[i]) w_msb_code = W'(i);
    end
  end

  // First set bit at or after w_rr_start in circular order.
  always_comb begin
    int idx;
    w_rr_code = '0;
    idx       = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(w_rr_start) + i;
      if (idx >= N) idx = idx - N;
      if (req[idx]) w_rr_code = W'(idx);
    end
  end

  // Zero and multi flags depend only on the population count of req.
  always_comb begin
    int cnt;
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + int'(req[i]);
    end
    w_zero  = (cnt == 0);
    w_multi = (cnt >= 2);
  end

  // Pick the code for the requested mode; the reserved mode acts as LSB-first.
  always_comb begin
    unique case (mode_e'(mode))
      MODE_MSB: w_sel_code = w_msb_code;
      MODE_RR:  w_sel_code = w_rr_code;
      default:  w_sel_code = w_lsb_code;
    endcase
  end

  // Output stage and round-robin pointer; reset overrides any transfer.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (rst) begin
      r_out_valid <= 1'b0;
      r_code      <= '0;
      r_zero      <= 1'b0;
      r_multi     <= 1'b0;
      r_ptr       <= W'(N - 1);
    end else begin
      if (w_in_xfer) begin
        r_out_valid <= 1'b1;
        r_code      <= w_sel_code;
        r_zero      <= w_zero;
        r_multi     <= w_multi;
        if (mode_e'(mode) == MODE_RR && !w_zero) r_ptr <= w_rr_code;
      end else if (w_out_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign code      = r_code;
  assign zero      = r_zero;
  assign multi     = r_multi;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: one instance with N=4 and one with N=5, driven
// by directed steps followed by random traffic, compared against a model
// that applies the selection rules directly to the request vector.
module tb_prio_encoder_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       iv4, rdy4, ov4, ordy4, zero4, multi4;
  logic [3:0] req4;
  logic [1:0] mode4, code4;
  logic       iv5, rdy5, ov5, ordy5, zero5, multi5;
  logic [4:0] req5;
  logic [1:0] mode5;
  logic [2:0] code5;

  prio_encoder_rr #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy4), .req(req4),
    .mode(mode4), .out_valid(ov4), .out_ready(ordy4), .code(code4),
    .zero(zero4), .multi(multi4)
  );

  prio_encoder_rr #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(rdy5), .req(req5),
    .mode(mode5), .out_valid(ov5), .out_ready(ordy5), .code(code5),
    .zero(zero5), .multi(multi5)
  );

  int errors = 0;
  int checks = 0;

  // Model state per instance: 0 -> N=4, 1 -> N=5.
  bit m_valid [2];
  int m_code  [2];
  bit m_zero  [2];
  bit m_multi [2];
  int m_ptr   [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int width_of(input int d);
    return (d == 0) ? 4 : 5;
  endfunction

  // Selected index straight from the rules: scan the set bits in the order
  // the mode dictates and return the first one met.
  function automatic int ref_code(input logic [63:0] r, input int n,
                                  input logic [1:0] m, input int p);
    if (r == 0) return 0;
    if (m == 2'b01) begin
      for (int i = n - 1; i >= 0; i--) if (r[i]) return i;
    end else if (m == 2'b10) begin
      for (int k = 1; k <= n; k++) if (r[(p + k) % n]) return (p + k) % n;
    end else begin
      for (int i = 0; i < n; i++) if (r[i]) return i;
    end
    return 0;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 0; m_code[d] = 0; m_zero[d] = 0; m_multi[d] = 0;
      m_ptr[d] = width_of(d) - 1;
    end
  endfunction

  task automatic check_outputs(input int d);
    if (d == 0) begin
      check("out_valid4", ov4, m_valid[0]);
      check("code4", code4, m_code[0]);
      check("zero4", zero4, m_zero[0]);
      check("multi4", multi4, m_multi[0]);
    end else begin
      check("out_valid5", ov5, m_valid[1]);
      check("code5", code5, m_code[1]);
      check("zero5", zero5, m_zero[1]);
      check("multi5", multi5, m_multi[1]);
    end
  endtask

  // One clock on instance d; the other instance idles with its result held.
  // Called just after a falling edge; returns just after the next one.
  task automatic step(input int d, input bit v, input logic [63:0] r_in,
                      input logic [1:0] m, input bit o_rdy);
    int          n;
    logic [63:0] r;
    bit          exp_rdy, in_x, out_x;
    n = width_of(d);
    r = r_in & ((64'd1 << n) - 1);
    iv4 = 0; ordy4 = 0; iv5 = 0; ordy5 = 0;
    if (d == 0) begin
      iv4 = v; req4 = r[3:0]; mode4 = m; ordy4 = o_rdy;
    end else begin
      iv5 = v; req5 = r[4:0]; mode5 = m; ordy5 = o_rdy;
    end
    #1;
    exp_rdy = !m_valid[d] || o_rdy;
    check(d == 0 ? "in_ready4" : "in_ready5", d == 0 ? rdy4 : rdy5, exp_rdy);
    in_x  = v && exp_rdy;
    out_x = m_valid[d] && o_rdy;
    @(posedge clk);
    if (in_x) begin
      m_valid[d] = 1;
      m_code[d]  = ref_code(r, n, m, m_ptr[d]);
      m_zero[d]  = (r == 0);
      m_multi[d] = ($countones(r) >= 2);
      if (m == 2'b10 && r != 0) m_ptr[d] = m_code[d];
    end else if (out_x) begin
      m_valid[d] = 0;
    end
    @(negedge clk);
    check_outputs(d);
  endtask

  // Reset both instances; instance 4 may offer a transfer that must be lost.
  task automatic do_reset(input bit v4);
    rst = 1; iv4 = v4; req4 = 4'b1111; mode4 = 2'b10; ordy4 = 1;
    iv5 = 0; ordy5 = 1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 0; iv4 = 0; ordy4 = 0; ordy5 = 0;
    #1;
    check_outputs(0);
    check_outputs(1);
    check("rst_in_ready4", rdy4, 1'b1);
    check("rst_in_ready5", rdy5, 1'b1);
  endtask

  initial begin
    int rr_exp [5];
    rst = 1; iv4 = 0; iv5 = 0; ordy4 = 0; ordy5 = 0;
    req4 = '0; req5 = '0; mode4 = '0; mode5 = '0;
    @(negedge clk);
    do_reset(1'b0);

    // One-hot sweep, LSB-first, consumer always ready.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 64'd1 << i, 2'b00, 1);
      check("sweep4_code", code4, i);
    end
    step(0, 0, 0, 2'b00, 1);

    // Priority of 0110 across modes.
    step(0, 1, 64'b0110, 2'b00, 1); check("prio_lsb", code4, 1); check("prio_multi", multi4, 1);
    step(0, 1, 64'b0110, 2'b01, 1); check("prio_msb", code4, 2);
    step(0, 1, 64'b0110, 2'b11, 1); check("prio_rsvd", code4, 1);

    // Round-robin from reset, with a zero request in the middle.
    do_reset(1'b0);
    rr_exp = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 64'b1111, 2'b10, 1);
      check("rr_seq", code4, rr_exp[i]);
    end
    step(0, 1, 64'b0000, 2'b10, 1);
    check("rr_zero", zero4, 1'b1); check("rr_zero_code", code4, 0);
    step(0, 1, 64'b1111, 2'b10, 1);
    check("rr_after_zero", code4, rr_exp[4]);

    // Backpressure: result 3 held while the consumer stalls.
    step(0, 1, 64'b1000, 2'b00, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 64'b0001, 2'b00, 0);
      check("bp_hold", code4, 3);
    end
    step(0, 0, 0, 2'b00, 1);

    // Reset with a result pending and the pointer at 2.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) step(0, 1, 64'b1111, 2'b10, 0 + (i > 0 ? 1 : 1));
    do_reset(1'b1);
    step(0, 1, 64'b1111, 2'b10, 1);
    check("rst_rr_code", code4, 0);

    // Non-power-of-two instance: sweep and round-robin wrap at 4.
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 64'd1 << i, 2'b01, 1);
      check("sweep5_code", code5, i);
    end
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 64'b11111, 2'b10, 1);
      check("rr5_seq", code5, i % 5);
    end

    // Random traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      step(i % 2, $urandom_range(0, 3) != 0, {$urandom, $urandom},
           2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
